// File: rtl/sdram_device_model.sv
// Synthesizable far-end responder for the 16-bit SDRAM wire interface: decodes
// commands, tracks open rows per bank, returns reads after CAS latency, flags misuse.
module sdram_device_model #(
  parameter int MEM_ADDR_BITS = 12,
  parameter int TRCD          = 2,
  parameter int COL_BITS      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [1:0]  ba,
  input  logic [11:0] addr,
  input  logic [1:0]  dqm,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic [1:0]  dq_oe,
  output logic [3:0]  err,
  output logic [15:0] refresh_cnt
);

  localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;
  localparam int MW = 1 << MEM_ADDR_BITS;

  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;

  logic [15:0]   r_mem [MW];
  logic [3:0]    r_open;
  logic [11:0]   r_row [4];
  logic [TW-1:0] r_trcd [4];
  logic [2:0]    r_cl;
  logic          r_mode_valid;
  logic [3:0]    r_err;
  logic [15:0]   r_refresh_cnt;
  logic [15:0]   r_dq_out;
  logic [1:0]    r_dq_oe;

  logic          r_vld_p0, r_vld_p1, r_vld_p2;
  logic [15:0]   r_dat_p0, r_dat_p1, r_dat_p2;
  logic [1:0]    r_msk_p0, r_msk_p1, r_msk_p2;

  logic                       w_cmd_en;
  logic [2:0]                 w_cmd;
  logic                       w_cas_ok;
  logic [13+COL_BITS:0]       w_full;
  logic [MEM_ADDR_BITS-1:0]   w_idx;
  logic [15:0]                w_rd_word;
  logic                       w_rd_ok, w_wr_ok, w_ins_p1, w_ins_p2;

  assign w_cmd_en  = cke & ~cs_n & ~rst;
  assign w_cmd     = {ras_n, cas_n, we_n};
  assign w_cas_ok  = r_open[ba] && (r_trcd[ba] == '0) && r_mode_valid;
  assign w_full    = {ba, r_row[ba], addr[COL_BITS-1:0]};
  assign w_idx     = w_full[MEM_ADDR_BITS-1:0];
  assign w_rd_word = r_mem[w_idx];
  assign w_rd_ok   = w_cmd_en && (w_cmd == CMD_RD) && w_cas_ok;
  assign w_wr_ok   = w_cmd_en && (w_cmd == CMD_WR) && w_cas_ok;
  // CL=3 enters at p2, CL=2 at p1, so data reaches the pins after edge T+CL
  assign w_ins_p2  = w_rd_ok && (r_cl == 3'd3);
  assign w_ins_p1  = w_rd_ok && (r_cl != 3'd3);

  assign dq_out      = r_dq_out;
  assign dq_oe       = r_dq_oe;
  assign err         = r_err;
  assign refresh_cnt = r_refresh_cnt;

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      if (!dqm[0]) r_mem[w_idx][7:0]  <= dq_in[7:0];
      if (!dqm[1]) r_mem[w_idx][15:8] <= dq_in[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (cke) begin
      r_dat_p0 <= r_dat_p1;
      r_msk_p0 <= r_msk_p1;
      r_dat_p1 <= w_ins_p1 ? w_rd_word : r_dat_p2;
      r_msk_p1 <= w_ins_p1 ? ~dqm : r_msk_p2;
      r_dat_p2 <= w_rd_word;
      r_msk_p2 <= ~dqm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_open        <= '0;
      r_cl          <= '0;
      r_mode_valid  <= 1'b0;
      r_err         <= '0;
      r_refresh_cnt <= '0;
      r_dq_out      <= '0;
      r_dq_oe       <= '0;
      r_vld_p0      <= 1'b0;
      r_vld_p1      <= 1'b0;
      r_vld_p2      <= 1'b0;
      for (int b = 0; b < 4; b++) r_trcd[b] <= '0;
    end else if (cke) begin
      for (int b = 0; b < 4; b++)
        if (r_trcd[b] != '0) r_trcd[b] <= r_trcd[b] - 1'b1;
      // p0 -> pins
      r_dq_oe <= r_vld_p0 ? r_msk_p0 : 2'b00;
      if (r_vld_p0) r_dq_out <= r_dat_p0;
      // p1 -> p0, p2 -> p1
      r_vld_p0 <= r_vld_p1;
      r_vld_p1 <= w_ins_p1 | r_vld_p2;
      r_vld_p2 <= w_ins_p2;
      if (w_cmd_en) begin
        case (w_cmd)
          CMD_ACT: begin
            if (r_open[ba]) r_err[0] <= 1'b1;
            else begin
              r_open[ba] <= 1'b1;
              r_row[ba]  <= addr;
              r_trcd[ba] <= TW'(TRCD - 1);
            end
          end
          CMD_RD, CMD_WR: begin
            if (!r_open[ba]) r_err[0] <= 1'b1;
            if (r_open[ba] && (r_trcd[ba] != '0)) r_err[1] <= 1'b1;
            if (!r_mode_valid) r_err[3] <= 1'b1;
          end
          CMD_PRE: begin
            if (addr[10]) r_open <= '0;
            else r_open[ba] <= 1'b0;
          end
          CMD_REF: begin
            r_refresh_cnt <= r_refresh_cnt + 16'd1;
            if (|r_open) r_err[2] <= 1'b1;
          end
          CMD_LMR: begin
            if (|r_open) r_err[2] <= 1'b1;
            else begin
              r_cl <= addr[6:4];
              r_mode_valid <= ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && (addr[2:0] == 3'd0);
              if (!(((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && (addr[2:0] == 3'd0)))
                r_err[3] <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model: mode programming, masked writes, CAS
// latency timing, protocol error flags, refresh counting, cke stall and reset flush.
module tb_sdram_device_model;

  logic        clk = 1'b0;
  logic        rst, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba, dqm;
  logic [11:0] addr;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic [1:0]  dq_oe;
  logic [3:0]  err;
  logic [15:0] refresh_cnt;

  int vecs = 0;
  int miss = 0;

  localparam logic [2:0] ACT = 3'b011, RD = 3'b101, WR = 3'b100, PRE = 3'b010,
                         REF = 3'b001, LMR = 3'b000;

  sdram_device_model dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .dqm(dqm), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .err(err), .refresh_cnt(refresh_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                     input logic [1:0] m, input logic [15:0] d);
    {ras_n, cas_n, we_n} = c;
    cs_n = 1'b0; ba = b; addr = a; dqm = m; dq_in = d;
    step();
    {ras_n, cas_n, we_n} = 3'b111;
    cs_n = 1'b1; dqm = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (dq_oe !== 2'b00) begin miss++; $display("FAIL reset_oe got %b want 00", dq_oe); end
    vecs++; if (dq_out !== 16'h0000) begin miss++; $display("FAIL reset_dq got %h want 0000", dq_out); end
    vecs++; if (err !== 4'b0000) begin miss++; $display("FAIL reset_err got %b want 0000", err); end
    vecs++; if (refresh_cnt !== 16'd0) begin miss++; $display("FAIL reset_ref got %0d want 0", refresh_cnt); end
    cmd(LMR, 2'd0, 12'h020, 2'b00, 16'h0);
    vecs++; if (err !== 4'b0000) begin miss++; $display("FAIL lmr_cl2_err got %b want 0000", err); end
  endtask

  task automatic test_write_read();
    cmd(ACT, 2'd1, 12'h055, 2'b00, 16'h0);
    step();
    cmd(WR, 2'd1, 12'h010, 2'b00, 16'hBEEF);
    cmd(RD, 2'd1, 12'h010, 2'b00, 16'h0);
    step();
    vecs++; if (dq_oe !== 2'b00) begin miss++; $display("FAIL wr_rd_early_oe got %b want 00", dq_oe); end
    step();
    vecs++; if (dq_oe !== 2'b11) begin miss++; $display("FAIL wr_rd_oe got %b want 11", dq_oe); end
    vecs++; if (dq_out !== 16'hBEEF) begin miss++; $display("FAIL wr_rd_data got %h want BEEF", dq_out); end
    step();
    vecs++; if (dq_oe !== 2'b00) begin miss++; $display("FAIL wr_rd_oe_drop got %b want 00", dq_oe); end
    vecs++; if (dq_out !== 16'hBEEF) begin miss++; $display("FAIL wr_rd_hold got %h want BEEF", dq_out); end
    vecs++; if (err !== 4'b0000) begin miss++; $display("FAIL wr_rd_err got %b want 0000", err); end
  endtask

  task automatic test_byte_mask();
    cmd(WR, 2'd1, 12'h010, 2'b10, 16'h1234);
    cmd(RD, 2'd1, 12'h010, 2'b01, 16'h0);
    step();
    step();
    vecs++; if (dq_oe !== 2'b10) begin miss++; $display("FAIL mask_oe got %b want 10", dq_oe); end
    vecs++; if (dq_out !== 16'hBE34) begin miss++; $display("FAIL mask_data got %h want BE34", dq_out); end
    step();
    vecs++; if (dq_oe !== 2'b00) begin miss++; $display("FAIL mask_oe_drop got %b want 00", dq_oe); end
  endtask

  task automatic test_errors();
    cmd(RD, 2'd2, 12'h010, 2'b00, 16'h0);
    vecs++; if (err !== 4'b0001) begin miss++; $display("FAIL idle_rd_err got %b want 0001", err); end
    cmd(ACT, 2'd3, 12'h001, 2'b00, 16'h0);
    cmd(RD, 2'd3, 12'h010, 2'b00, 16'h0);
    vecs++; if (err !== 4'b0011) begin miss++; $display("FAIL trcd_err got %b want 0011", err); end
    for (int i = 0; i < 4; i++) begin
      step();
      vecs++; if (dq_oe !== 2'b00) begin miss++; $display("FAIL err_no_data[%0d] got %b want 00", i, dq_oe); end
    end
  endtask

  task automatic test_refresh();
    do_reset();
    for (int i = 0; i < 3; i++) cmd(REF, 2'd0, 12'h000, 2'b00, 16'h0);
    vecs++; if (refresh_cnt !== 16'd3) begin miss++; $display("FAIL ref_cnt3 got %0d want 3", refresh_cnt); end
    vecs++; if (err !== 4'b0000) begin miss++; $display("FAIL ref_idle_err got %b want 0000", err); end
    cmd(ACT, 2'd0, 12'h000, 2'b00, 16'h0);
    cmd(REF, 2'd0, 12'h000, 2'b00, 16'h0);
    vecs++; if (refresh_cnt !== 16'd4) begin miss++; $display("FAIL ref_cnt4 got %0d want 4", refresh_cnt); end
    vecs++; if (err !== 4'b0100) begin miss++; $display("FAIL ref_open_err got %b want 0100", err); end
  endtask

  task automatic test_cl3_stall();
    logic [15:0] exp;
    do_reset();
    cmd(LMR, 2'd0, 12'h030, 2'b00, 16'h0);
    cmd(ACT, 2'd1, 12'h055, 2'b00, 16'h0);
    step();
    for (int i = 0; i < 4; i++) cmd(WR, 2'd1, 12'h020 + 12'(i), 2'b00, 16'hA000 + 16'(i));
    for (int i = 0; i < 4; i++) begin
      cmd(RD, 2'd1, 12'h020 + 12'(i), 2'b00, 16'h0);
      if (i == 2) begin
        vecs++; if (dq_oe !== 2'b00) begin miss++; $display("FAIL cl3_early_oe got %b want 00", dq_oe); end
      end
    end
    vecs++; if (dq_oe !== 2'b11 || dq_out !== 16'hA000) begin
      miss++; $display("FAIL cl3_beat0 got oe=%b dq=%h want oe=11 dq=A000", dq_oe, dq_out); end
    cke = 1'b0;
    cmd(RD, 2'd1, 12'h010, 2'b00, 16'h0);
    cke = 1'b1;
    vecs++; if (dq_oe !== 2'b11 || dq_out !== 16'hA000) begin
      miss++; $display("FAIL cl3_stall_hold got oe=%b dq=%h want oe=11 dq=A000", dq_oe, dq_out); end
    for (int i = 1; i < 4; i++) begin
      step();
      exp = 16'hA000 + 16'(i);
      vecs++; if (dq_oe !== 2'b11 || dq_out !== exp) begin
        miss++; $display("FAIL cl3_beat%0d got oe=%b dq=%h want oe=11 dq=%h", i, dq_oe, dq_out, exp); end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vecs++; if (dq_oe !== 2'b00) begin miss++; $display("FAIL cl3_tail[%0d] got %b want 00", i, dq_oe); end
    end
    vecs++; if (err !== 4'b0000) begin miss++; $display("FAIL cl3_err got %b want 0000", err); end
  endtask

  task automatic test_reset_flush();
    cmd(RD, 2'd2, 12'h000, 2'b00, 16'h0);
    for (int i = 0; i < 3; i++) cmd(RD, 2'd1, 12'h020 + 12'(i), 2'b00, 16'h0);
    step();
    vecs++; if (dq_oe !== 2'b11 || dq_out !== 16'hA000) begin
      miss++; $display("FAIL flush_beat0 got oe=%b dq=%h want oe=11 dq=A000", dq_oe, dq_out); end
    vecs++; if (err !== 4'b0001) begin miss++; $display("FAIL flush_pre_err got %b want 0001", err); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++; if (dq_oe !== 2'b00) begin miss++; $display("FAIL flush_oe got %b want 00", dq_oe); end
    vecs++; if (err !== 4'b0000) begin miss++; $display("FAIL flush_err got %b want 0000", err); end
    vecs++; if (dq_out !== 16'h0000) begin miss++; $display("FAIL flush_dq got %h want 0000", dq_out); end
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (dq_oe !== 2'b00) begin miss++; $display("FAIL flush_tail[%0d] got %b want 00", i, dq_oe); end
    end
  endtask

  initial begin
    rst = 1'b1; cke = 1'b1; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    ba = 2'd0; addr = 12'h000; dqm = 2'b00; dq_in = 16'h0000;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_errors();
    test_refresh();
    test_cl3_stall();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
